// File: rtl/riscv_led_monitor.sv
// Board-level debug monitor: pages PC, a watched register, retire count and cycle count onto an LED bank.
// It also provides freeze-frame snapshots and sticky detection of a jump-to-self loop.
module riscv_led_monitor #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned LED_W        = 16,
  parameter int unsigned WATCH_REG    = 2,
  parameter int unsigned HALT_CYCLES  = 8,
  parameter int unsigned SCROLL_TICKS = 50_000_000,
  localparam int unsigned PAGES       = XLEN / LED_W,
  localparam int unsigned PW          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc,
  input  logic             retire,
  input  logic             wb_en,
  input  logic [4:0]       wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [1:0]       chan_sel,
  input  logic [PW-1:0]    page_sel,
  input  logic             auto_page,
  input  logic             freeze,
  output logic [LED_W-1:0] leds,
  output logic [PW-1:0]    page_idx,
  output logic             halted
);

  localparam int unsigned TW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam int unsigned HW = $clog2(HALT_CYCLES + 1);

  logic [XLEN-1:0] cyc_cnt;
  logic [XLEN-1:0] ret_cnt;
  logic [XLEN-1:0] shadow;
  logic [XLEN-1:0] last_pc;
  logic            last_valid;
  logic [HW-1:0]   halt_ctr;
  logic [XLEN-1:0] snap [4];
  logic            freeze_d;
  logic [TW-1:0]   tick;

  logic            capture_c;
  logic [XLEN-1:0] live_sel_c;
  logic [XLEN-1:0] src_c;

  // Channel select; on the capture cycle the live value is shown so the frozen frame appears immediately
  always_comb begin
    live_sel_c = '0;
    case (chan_sel)
      2'd0:    live_sel_c = last_pc;
      2'd1:    live_sel_c = shadow;
      2'd2:    live_sel_c = ret_cnt;
      default: live_sel_c = cyc_cnt;
    endcase
    capture_c = freeze & ~freeze_d;
    src_c     = (freeze && !capture_c) ? snap[chan_sel] : live_sel_c;
  end

  // Live counters, watched-register shadow and snapshots
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= '0;
      ret_cnt  <= '0;
      shadow   <= '0;
      freeze_d <= 1'b1;
      for (int i = 0; i < 4; i++) snap[i] <= '0;
    end else begin
      cyc_cnt  <= cyc_cnt + XLEN'(1);
      freeze_d <= freeze;
      if (retire) ret_cnt <= ret_cnt + XLEN'(1);
      if (WATCH_REG != 0 && wb_en && wb_addr == 5'(WATCH_REG)) shadow <= wb_data;
      if (capture_c) begin
        snap[0] <= last_pc;
        snap[1] <= shadow;
        snap[2] <= ret_cnt;
        snap[3] <= cyc_cnt;
      end
    end
  end

  // Jump-to-self detection: count consecutive retires at an unchanged PC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pc    <= '0;
      last_valid <= 1'b0;
      halt_ctr   <= '0;
      halted     <= 1'b0;
    end else begin
      halted <= halted | (halt_ctr == HW'(HALT_CYCLES));
      if (retire) begin
        last_pc    <= pc;
        last_valid <= 1'b1;
        if (last_valid && pc == last_pc) begin
          if (halt_ctr != HW'(HALT_CYCLES)) halt_ctr <= halt_ctr + HW'(1);
        end else begin
          halt_ctr <= '0;
        end
      end
    end
  end

  // Page selection, manual or auto-scrolled from the current page
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick     <= '0;
      page_idx <= '0;
    end else if (PAGES == 1) begin
      tick     <= '0;
      page_idx <= '0;
    end else if (!auto_page) begin
      tick     <= '0;
      page_idx <= page_sel;
    end else if (tick == TW'(SCROLL_TICKS - 1)) begin
      tick     <= '0;
      page_idx <= (page_idx == PW'(PAGES - 1)) ? '0 : page_idx + PW'(1);
    end else begin
      tick <= tick + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) leds <= '0;
    else     leds <= LED_W'(src_c >> (LED_W * int'(page_idx)));
  end

endmodule

// File: tb/tb_riscv_led_monitor.sv
// Directed and random checks of riscv_led_monitor against a cycle-level behavioural model.
module tb_riscv_led_monitor;

  localparam int HC = 4;
  localparam int ST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        retire;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [1:0]  chan_sel;
  logic [0:0]  page_sel;
  logic        auto_page;
  logic        freeze;
  logic [15:0] leds;
  logic [0:0]  page_idx;
  logic        halted;

  int errors = 0;
  int checks = 0;

  riscv_led_monitor #(
    .XLEN(32), .LED_W(16), .WATCH_REG(2), .HALT_CYCLES(HC), .SCROLL_TICKS(ST)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc), .retire(retire), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .chan_sel(chan_sel), .page_sel(page_sel), .auto_page(auto_page),
    .freeze(freeze), .leds(leds), .page_idx(page_idx), .halted(halted)
  );

  always #5 clk = ~clk;

  // Reference model state: values the DUT should hold after the next clock edge
  logic [31:0] m_cyc, m_ret, m_shadow, m_last_pc;
  logic [31:0] m_snap [4];
  bit          m_last_valid, m_halted, m_fprev;
  int          m_repeat, m_tick, m_page;
  logic [15:0] m_leds;

  task automatic model_reset();
    m_cyc = 0; m_ret = 0; m_shadow = 0; m_last_pc = 0;
    for (int i = 0; i < 4; i++) m_snap[i] = 0;
    m_last_valid = 0; m_halted = 0; m_fprev = 1;
    m_repeat = 0; m_tick = 0; m_page = 0; m_leds = 0;
  endtask

  task automatic model_step();
    logic [31:0] lv [4];
    logic [31:0] src;
    if (rst) begin
      model_reset();
      return;
    end
    lv[0] = m_last_pc; lv[1] = m_shadow; lv[2] = m_ret; lv[3] = m_cyc;
    if (freeze && !m_fprev) for (int i = 0; i < 4; i++) m_snap[i] = lv[i];
    src    = freeze ? m_snap[chan_sel] : lv[chan_sel];
    m_leds = 16'(src >> (16 * m_page));
    if (m_repeat >= HC) m_halted = 1;
    if (retire) begin
      if (m_last_valid && pc == m_last_pc) m_repeat = (m_repeat < HC) ? m_repeat + 1 : HC;
      else m_repeat = 0;
      m_last_pc = pc;
      m_last_valid = 1;
      m_ret = m_ret + 1;
    end
    m_cyc = m_cyc + 1;
    if (wb_en && wb_addr == 5'd2) m_shadow = wb_data;
    if (!auto_page) begin
      m_tick = 0;
      m_page = int'(page_sel);
    end else if (m_tick == ST - 1) begin
      m_tick = 0;
      m_page = (m_page + 1) % 2;
    end else begin
      m_tick++;
    end
    m_fprev = freeze;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("leds", 32'(leds), 32'(m_leds));
    chk("page_idx", 32'(page_idx), 32'(m_page));
    chk("halted", 32'(halted), 32'(m_halted));
  endtask

  task automatic do_retire(input logic [31:0] addr);
    pc = addr;
    retire = 1'b1;
    step();
    retire = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc = '0; retire = 0; wb_en = 0; wb_addr = '0; wb_data = '0;
    chan_sel = 2'd3; page_sel = '0; auto_page = 0; freeze = 0;
    model_reset();
    #3;
    chk("reset_leds", 32'(leds), 32'h0);
    chk("reset_halted", 32'(halted), 32'h0);
    chk("reset_page", 32'(page_idx), 32'h0);
    step(); step();

    // Cycle counter on page 0 lags by one clock
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("cyc_lag", 32'(leds), 32'd3);

    // Watched register shadow and manual paging
    chan_sel = 2'd1; wb_en = 1; wb_addr = 5'd2; wb_data = 32'hDEAD_BEEF;
    step();
    wb_en = 0;
    step();
    chk("watch_lo", 32'(leds), 32'hBEEF);
    page_sel = 1'b1;
    step(); step();
    chk("watch_hi", 32'(leds), 32'hDEAD);
    wb_en = 1; wb_addr = 5'd3; wb_data = 32'h1234_5678;
    step();
    wb_en = 0;
    step();
    chk("watch_other", 32'(leds), 32'hDEAD);
    page_sel = 1'b0;
    step(); step();

    // Auto scroll every ST clocks
    auto_page = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 4) chk("auto_p1", 32'(page_idx), 32'd1);
      if (i == 5) chk("auto_hi", 32'(leds), 32'hDEAD);
      if (i == 8) chk("auto_p0", 32'(page_idx), 32'd0);
    end
    auto_page = 1'b0;
    page_sel = 1'b0;
    step();

    // Jump-to-self detection, interrupted then completed
    chan_sel = 2'd0;
    do_retire(32'h10);
    do_retire(32'h14);
    for (int i = 0; i < 3; i++) do_retire(32'h14);
    do_retire(32'h18);
    step();
    chk("halt_interrupted", 32'(halted), 32'h0);
    for (int i = 0; i < 3; i++) do_retire(32'h18);
    step();
    do_retire(32'h18);
    chk("halt_not_yet", 32'(halted), 32'h0);
    step();
    chk("halt_set", 32'(halted), 32'h1);

    // Async reset mid-run with freeze high
    chan_sel = 2'd3; page_sel = 1'b1;
    step();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    #1;
    chk("async_leds", 32'(leds), 32'h0);
    chk("async_halted", 32'(halted), 32'h0);
    chk("async_page", 32'(page_idx), 32'h0);
    model_reset();
    page_sel = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("no_snap_after_rst", 32'(leds), 32'h0);
    freeze = 1'b0;
    step(); step();
    freeze = 1'b1;
    step(); step(); step();

    // Freeze captures pre-retire count
    rst = 1'b1; freeze = 1'b0;
    step();
    rst = 1'b0; chan_sel = 2'd2;
    step();
    for (int i = 0; i < 5; i++) do_retire(32'h100 + 32'(4 * i));
    freeze = 1'b1;
    do_retire(32'h200);
    chk("freeze_5", 32'(leds), 32'd5);
    for (int i = 0; i < 9; i++) begin
      do_retire(32'h204 + 32'(4 * i));
      chk("freeze_hold", 32'(leds), 32'd5);
    end
    freeze = 1'b0;
    step();
    chk("unfreeze_15", 32'(leds), 32'd15);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      retire    = $urandom_range(0, 1);
      pc        = 32'h400 + 32'(4 * $urandom_range(0, 2));
      wb_en     = $urandom_range(0, 1);
      wb_addr   = 5'($urandom_range(1, 3));
      wb_data   = $urandom;
      chan_sel  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) page_sel = ~page_sel;
      if ($urandom_range(0, 15) == 0) auto_page = ~auto_page;
      if ($urandom_range(0, 9) == 0) freeze = ~freeze;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
